// File: rtl/servo_pwm.sv
// servo_pwm: hobby-servo PWM frame generator driven by a 20-bit angle command.
// Define SERVO_SLEW_EN to limit active_angle changes to MAX_STEP per frame.
module servo_pwm #(
    parameter int unsigned PERIOD      = 1_000_000,
    parameter int unsigned MIN_PULSE   = 50_000,
    parameter int unsigned ANGLE_SHIFT = 2,
    parameter int unsigned ANGLE_MAX   = 196_605,
    parameter int unsigned ANGLE_RESET = 98_304,
    parameter int unsigned MAX_STEP    = 4_096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [19:0] angle,
    output logic        pwm,
    output logic        frame_start,
    output logic [19:0] active_angle,
    output logic        clamped
);
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    localparam logic [19:0] LP_LAST = 20'(PERIOD - 1);
    localparam logic [19:0] LP_AMAX = 20'(ANGLE_MAX);
    localparam logic [19:0] LP_ARST = 20'(ANGLE_RESET);
    localparam logic [19:0] LP_MINP = 20'(MIN_PULSE);

    if (MIN_PULSE < 1 || MIN_PULSE + (ANGLE_MAX >> ANGLE_SHIFT) >= PERIOD
        || PERIOD > (1 << 20) || MAX_STEP >= (1 << 20)) begin : g_bad_params
        $error("servo_pwm: illegal parameter set");
    end

    state_t      r_state, w_state_n;
    logic [19:0] r_cnt, w_cnt_n;
    logic [19:0] r_pulse_len, w_pulse_len_n;
    logic [19:0] r_active, w_active_n;
    logic [19:0] w_target, w_next_angle;
    logic        r_pwm, w_pwm_n;
    logic        r_fs, w_fs_n;
    logic        r_clamped, w_clamped_n;
    logic        w_start, w_over;

    assign w_over   = angle > LP_AMAX;
    assign w_target = w_over ? LP_AMAX : angle;

`ifdef SERVO_SLEW_EN
    localparam logic [19:0] LP_STEP = 20'(MAX_STEP);
    logic [19:0] w_diff;

    // Differences are taken larger-minus-smaller so nothing underflows.
    always_comb begin
        w_next_angle = w_target;
        w_diff       = '0;
        if (w_target > r_active) begin
            w_diff = w_target - r_active;
            if (w_diff > LP_STEP)
                w_next_angle = r_active + LP_STEP;
        end else begin
            w_diff = r_active - w_target;
            if (w_diff > LP_STEP)
                w_next_angle = r_active - LP_STEP;
        end
    end
`else
    assign w_next_angle = w_target;
`endif

    assign w_start = enable &&
        (r_state == S_IDLE || (r_state == S_LOW && r_cnt == LP_LAST));

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_pulse_len_n = r_pulse_len;
        w_active_n    = r_active;
        w_clamped_n   = r_clamped;
        w_fs_n        = 1'b0;
        if (w_start) begin
            w_state_n     = S_HIGH;
            w_cnt_n       = '0;
            w_fs_n        = 1'b1;
            w_active_n    = w_next_angle;
            w_clamped_n   = w_over;
            w_pulse_len_n = LP_MINP + (w_next_angle >> ANGLE_SHIFT);
        end else begin
            unique case (r_state)
                S_HIGH: begin
                    w_cnt_n = r_cnt + 20'd1;
                    if (r_cnt == r_pulse_len - 20'd1)
                        w_state_n = S_LOW;
                end
                S_LOW: begin
                    if (r_cnt == LP_LAST) begin
                        w_state_n = S_IDLE;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + 20'd1;
                    end
                end
                default: ;
            endcase
        end
        w_pwm_n = (w_state_n == S_HIGH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pulse_len <= '0;
            r_active    <= LP_ARST;
            r_clamped   <= 1'b0;
            r_pwm       <= 1'b0;
            r_fs        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_pulse_len <= w_pulse_len_n;
            r_active    <= w_active_n;
            r_clamped   <= w_clamped_n;
            r_pwm       <= w_pwm_n;
            r_fs        <= w_fs_n;
        end
    end

    assign pwm          = r_pwm;
    assign frame_start  = r_fs;
    assign active_angle = r_active;
    assign clamped      = r_clamped;
endmodule

// File: doc/servo_pwm.md
# servo_pwm

Servo pulse generator that consumes the 20-bit `angle` command produced by the button-driven angle controller and drives a standard hobby-servo PWM line. It emits one fixed-length frame per `PERIOD` clocks. The high time of each frame is a linear function of the angle, which is sampled once at the frame boundary. It sits between the angle controller and the servo output pin.

## Interface
Parameters:
- `PERIOD`, 1_000_000: frame length in clocks (20 ms at 50 MHz).
- `MIN_PULSE`, 50_000: high time in clocks at angle 0 (1 ms).
- `ANGLE_SHIFT`, 2: right shift applied to the angle before it is added to `MIN_PULSE`.
- `ANGLE_MAX`, 196_605: largest legal angle (180°); larger inputs are clamped to this value.
- `ANGLE_RESET`, 98_304: reset value of the active angle (90°).
- `MAX_STEP`, 4_096: largest per-frame change of the active angle; used only with `SERVO_SLEW_EN`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request; sampled only in IDLE and at the end of a frame.
- `angle` in 20: commanded angle (0 = 0°, 98_304 = 90°, 196_605 = 180°).
- `pwm` out 1: registered servo drive.
- `frame_start` out 1: one-cycle pulse on the first cycle of each frame.
- `active_angle` out 20: angle in use for the current frame.
- `clamped` out 1: set for a whole frame when that frame's sampled `angle` exceeded `ANGLE_MAX`.

## Operation
- FSM states: IDLE, HIGH, LOW. A frame counter `cnt` (20 bits) runs 0..`PERIOD`-1.
- Frame start happens on a clock edge in either of two cases: IDLE with `enable`=1, or LOW with `cnt`=`PERIOD`-1 and `enable`=1. On that edge:
  - `cnt` goes to 0 and the state goes to HIGH.
  - `pwm` goes to 1 and `frame_start` goes to 1.
  - The target is `min(angle, ANGLE_MAX)`. `clamped` is 1 if `angle` > `ANGLE_MAX`, otherwise 0.
  - `active_angle` is loaded with the target (see Configuration for the slew variant).
  - `pulse_len` is registered as `MIN_PULSE + (new active_angle >> ANGLE_SHIFT)`. All arithmetic is unsigned, 20 bits, and cannot overflow for legal parameters.
- HIGH: `cnt` increments each clock. When `cnt`=`pulse_len`-1, the state goes to LOW and `pwm` goes to 0 on the next edge.
- LOW: `cnt` increments each clock. At `cnt`=`PERIOD`-1:
  - If `enable`=1, a new frame starts (no gap).
  - If `enable`=0, the state goes to IDLE, `cnt` goes to 0 and `pwm` stays 0.
- `enable` falling mid-frame does not truncate the frame. No runt pulses are ever generated.
- Changes to `angle` mid-frame have no effect until the next frame start.
- Parameter legality (implementation must not need to handle violations): `MIN_PULSE`≥1 and `MIN_PULSE + (ANGLE_MAX >> ANGLE_SHIFT)` < `PERIOD` ≤ 2^20.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `cnt` 0, `pwm` 0, `frame_start` 0, `active_angle` = `ANGLE_RESET`, `clamped` 0.
- Reset asserted mid-pulse forces `pwm` low in the same instant, with no clock needed.
- Latency: `pwm` and `frame_start` go high on the same edge that samples `enable`=1 in IDLE.
- `pwm` is high for exactly `pulse_len` clocks per frame. A frame is exactly `PERIOD` clocks.
- `frame_start` is high for exactly one clock per frame.
- `active_angle` and `clamped` update only on frame-start edges and are stable otherwise.

## Configuration
- Macro: `SERVO_SLEW_EN`.
- When defined: at each frame start, `active_angle` moves toward the target by at most `MAX_STEP`.
  - If |target − active| ≤ `MAX_STEP`, `active_angle` becomes the target.
  - The subtraction must not underflow. `active_angle` never overshoots and never leaves 0..`ANGLE_MAX`.
- When undefined: `active_angle` takes the target directly, `MAX_STEP` is ignored, and no slew logic is synthesized.

## Test plan
- Reset, `angle`=98_304, `enable`=1 → `frame_start` pulses on the first edge; `pwm` is high 74_576 clocks then low 925_424; the next `frame_start` comes 1_000_000 clocks later.
- `angle`=0, then `angle`=196_605 on successive frames → high times of 50_000 and 99_151; `active_angle` reads 0 then 196_605.
- `angle`=20'hFFFFF → `clamped`=1, `active_angle`=196_605, high time 99_151; the next frame with `angle`=10 → `clamped`=0.
- `angle` changed from 0 to 196_605 at clock 30_000 of a frame → current frame high time stays 50_000; the next frame's high time is 99_151.
- `enable` dropped at clock 10 of a frame → frame completes normally, FSM enters IDLE, `pwm` stays 0. Separately, `reset` pulsed at clock 20_000 → `pwm` goes 0 immediately and `active_angle`=98_304.
- With `SERVO_SLEW_EN`, `MAX_STEP`=4_096, `angle`=0 held after reset → `active_angle` steps 94_208, 90_112, …, reaching 0 on the 24th frame and staying there.
